// File: rtl/libdecode.sv
// Shared decode helpers used across the front end.
package libdecode;

    // Compressed instructions are identified by their two low opcode bits.
    function automatic logic is_inst_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/liborv32s.sv
// Front-end types: halfword indexing within a fetch line and instruction length.
package liborv32s;

    import libdecode::*;

    typedef logic [1:0] hw_idx_t;

    localparam int unsigned HwPerLine = 4;

    // Instruction length in halfwords: 1 for RVC, 2 for RV32.
    function automatic logic [2:0] inst_len_hw(input logic [15:0] hw);
        return is_inst_rvc(hw) ? 3'd1 : 3'd2;
    endfunction

endpackage

// File: rtl/inst_align.sv
// Extracts the instruction at a halfword index from the head line, borrowing
// the first halfword of the next line when an RV32 straddles the boundary.
module inst_align
    import liborv32s::*;
#(
    parameter int unsigned LINEWIDTH = 64
) (
    input  logic [LINEWIDTH-1:0] i_head_line,
    input  logic [15:0]          i_next_hw,
    input  hw_idx_t              i_hw_ptr,
    output logic [31:0]          o_inst,
    output logic [2:0]           o_size,
    output logic                 o_span
);

    logic [15:0] w_lo;
    logic [15:0] w_hi;

    always_comb begin
        w_lo = '0;
        w_hi = '0;
        unique case (i_hw_ptr)
            2'd0: begin w_lo = i_head_line[15:0];  w_hi = i_head_line[31:16]; end
            2'd1: begin w_lo = i_head_line[31:16]; w_hi = i_head_line[47:32]; end
            2'd2: begin w_lo = i_head_line[47:32]; w_hi = i_head_line[63:48]; end
            2'd3: begin w_lo = i_head_line[63:48]; w_hi = i_next_hw;          end
            default: ;
        endcase
    end

    always_comb begin
        o_size = inst_len_hw(w_lo);
        o_inst = (o_size == 3'd1) ? {16'h0000, w_lo} : {w_hi, w_lo};
        o_span = (i_hw_ptr == 2'd3) && (o_size == 3'd2);
    end

endmodule

// File: rtl/inst_buffer.sv
// Fetch-line FIFO feeding decode one RV32/RVC instruction per cycle, with
// line-straddling RV32 support, flush/redirect and stall hold.
module inst_buffer
    import liborv32s::*;
#(
    parameter int unsigned LINEWIDTH = 64,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LINEWIDTH-1:0] fetch_data_i,
    input  logic                 fetch_valid_i,
    output logic                 fetch_ready_o,
    input  logic                 flush_i,
    input  logic [31:0]          redirect_pc_i,
    input  logic                 stall,
    output logic [31:0]          inst_o,
    output logic                 inst_valid_o,
    output logic [31:0]          inst_pc_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [LINEWIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]      r_rd_ptr;
    logic [PtrW-1:0]      r_wr_ptr;
    logic [CntW-1:0]      r_count;
    hw_idx_t              r_hw_ptr;
    logic [31:0]          r_pc;

    logic [PtrW-1:0] w_next_ptr;
    logic [31:0]     w_inst;
    logic [2:0]      w_size;
    logic            w_span;
    logic            w_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_consume;
    logic [2:0]      w_hw_sum;

    assign w_next_ptr = r_rd_ptr + PtrW'(1);

    inst_align #(
        .LINEWIDTH (LINEWIDTH)
    ) u_inst_align (
        .i_head_line (r_mem[r_rd_ptr]),
        .i_next_hw   (r_mem[w_next_ptr][15:0]),
        .i_hw_ptr    (r_hw_ptr),
        .o_inst      (w_inst),
        .o_size      (w_size),
        .o_span      (w_span)
    );

    always_comb begin
        // A straddling RV32 needs the following line before it can issue.
        w_valid       = (r_count != '0) && !flush_i && (!w_span || (r_count >= CntW'(2)));
        inst_valid_o  = w_valid;
        inst_o        = w_valid ? w_inst : 32'h0;
        inst_pc_o     = r_pc;
        fetch_ready_o = rst && (r_count < CntW'(DEPTH)) && !flush_i;
        w_push        = fetch_valid_i && fetch_ready_o;
        w_consume     = w_valid && !stall;
        w_hw_sum      = {1'b0, r_hw_ptr} + w_size;
        w_pop         = w_consume && w_hw_sum[2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= fetch_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_next_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hw_ptr <= BOOT_ADDR[2:1];
            r_pc     <= BOOT_ADDR;
        end else if (flush_i) begin
            r_hw_ptr <= redirect_pc_i[2:1];
            r_pc     <= {redirect_pc_i[31:1], 1'b0};
        end else if (w_consume) begin
            r_hw_ptr <= w_hw_sum[1:0];
            r_pc     <= r_pc + 32'({w_size, 1'b0});
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: directed lines, expected {inst, pc} queued
// at stimulus time and checked by an independent monitor at each issue.
module tb_inst_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] fetch_data_i = '0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic        flush_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall = 1'b0;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [31:0] inst_pc_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb [$];
    logic [63:0] m_exp;

    always #5 clk = ~clk;

    inst_buffer #(
        .LINEWIDTH (64),
        .DEPTH     (2),
        .BOOT_ADDR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_data_i  (fetch_data_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .stall         (stall),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .inst_pc_o     (inst_pc_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] inst, input logic [31:0] pc);
        sb.push_back({inst, pc});
    endtask

    // Monitor: every issued instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (inst_valid_o && !stall) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got inst %h pc %h, expected none",
                             inst_o, inst_pc_o);
                end else begin
                    m_exp = sb.pop_front();
                    check("issue_inst", {32'h0, inst_o}, {32'h0, m_exp[63:32]});
                    check("issue_pc", {32'h0, inst_pc_o}, {32'h0, m_exp[31:0]});
                end
            end else if (!inst_valid_o) begin
                check("bubble_zero", {32'h0, inst_o}, 64'h0);
            end
        end
    end

    task automatic push_line(input logic [63:0] d);
        @(posedge clk);
        #1;
        fetch_data_i  = d;
        fetch_valid_i = 1'b1;
        @(posedge clk);
        #1;
        fetch_valid_i = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        @(posedge clk);
        #1;
        flush_i       = 1'b1;
        redirect_pc_i = pc;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d instructions never issued, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle(input string name);
        repeat (2) @(posedge clk);
        #1;
        check(name, {63'h0, inst_valid_o}, 64'h0);
    endtask

    initial begin
        // Reset state while rst is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'h0, inst_valid_o}, 64'h0);
        check("rst_inst", {32'h0, inst_o}, 64'h0);
        check("rst_ready", {63'h0, fetch_ready_o}, 64'h0);
        check("rst_pc", {32'h0, inst_pc_o}, 64'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", {63'h0, fetch_ready_o}, 64'h1);

        // Two RV32 nops in one line; line pops after the second.
        expect_inst(32'h0000_0013, 32'h0);
        expect_inst(32'h0000_0013, 32'h4);
        push_line(64'h00000013_00000013);
        wait_drain("rv32_pair_drain", 10);
        check_idle("rv32_pair_popped");

        // Four RVC on consecutive cycles.
        do_flush(32'h0);
        expect_inst(32'h1, 32'h0);
        expect_inst(32'h1, 32'h2);
        expect_inst(32'h1, 32'h4);
        expect_inst(32'h1, 32'h6);
        push_line(64'h0001_0001_0001_0001);
        repeat (4) @(posedge clk);
        #1;
        check("rvc_consecutive", 64'(sb.size()), 64'h0);
        wait_drain("rvc_drain", 10);
        check_idle("rvc_popped");

        // RV32 straddling two lines waits for the second push.
        do_flush(32'h0);
        expect_inst(32'h1, 32'h0);
        expect_inst(32'h1, 32'h2);
        expect_inst(32'h1, 32'h4);
        push_line(64'h0013_0001_0001_0001);
        repeat (6) @(posedge clk);
        #1;
        check("span_prefix", 64'(sb.size()), 64'h0);
        check("span_wait", {63'h0, inst_valid_o}, 64'h0);
        expect_inst(32'h0000_0013, 32'h6);
        expect_inst(32'h1, 32'hA);
        expect_inst(32'h1, 32'hC);
        expect_inst(32'h1, 32'hE);
        push_line(64'h0001_0001_0001_0000);
        wait_drain("span_drain", 10);
        check_idle("span_popped");

        // Full buffer under stall holds outputs, then drains without loss.
        do_flush(32'h0);
        stall = 1'b1;
        expect_inst(32'h0000_0013, 32'h0);
        expect_inst(32'h0010_0093, 32'h4);
        expect_inst(32'h0020_0113, 32'h8);
        expect_inst(32'h0030_0193, 32'hC);
        push_line(64'h00100093_00000013);
        push_line(64'h00300193_00200113);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_ready", {63'h0, fetch_ready_o}, 64'h0);
            check("stall_valid", {63'h0, inst_valid_o}, 64'h1);
            check("stall_inst", {32'h0, inst_o}, 64'h13);
            check("stall_pc", {32'h0, inst_pc_o}, 64'h0);
        end
        stall = 1'b0;
        wait_drain("stall_drain", 20);
        check_idle("stall_popped");

        // Flush concurrent with a push drops the line and redirects.
        @(posedge clk);
        #1;
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0000_0106;
        fetch_data_i  = 64'h0009_0009_0009_0009;
        fetch_valid_i = 1'b1;
        #1;
        check("flush_ready", {63'h0, fetch_ready_o}, 64'h0);
        check("flush_valid", {63'h0, inst_valid_o}, 64'h0);
        @(posedge clk);
        #1;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        check_idle("flush_dropped");
        expect_inst(32'h5, 32'h106);
        push_line(64'h0005_0000_0000_0000);
        wait_drain("redirect_drain", 10);
        check_idle("redirect_popped");

        // Reset mid-line: outputs drop at once, restart at BOOT_ADDR.
        do_flush(32'h0);
        expect_inst(32'h1, 32'h0);
        expect_inst(32'h1, 32'h2);
        push_line(64'h0001_0001_0001_0001);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_issue", 64'(sb.size()), 64'h0);
        rst = 1'b0;
        #1;
        check("midrst_valid", {63'h0, inst_valid_o}, 64'h0);
        check("midrst_inst", {32'h0, inst_o}, 64'h0);
        check("midrst_ready", {63'h0, fetch_ready_o}, 64'h0);
        check("midrst_pc", {32'h0, inst_pc_o}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_replay", {63'h0, inst_valid_o}, 64'h0);
        expect_inst(32'h0000_0013, 32'h0);
        expect_inst(32'h0000_0013, 32'h4);
        push_line(64'h00000013_00000013);
        wait_drain("restart_drain", 10);
        check_idle("restart_popped");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter LINEWIDTH, default 64, fetch line width in bits (fixed at 64; four halfwords).
REQ-002 SHALL have parameter DEPTH, default 2, number of line entries held (power of two, >=2).
REQ-003 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, PC of the first instruction after reset.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port fetch_data_i, input, LINEWIDTH, 8-byte-aligned fetch line, halfword 0 at [15:0].
REQ-007 SHALL have port fetch_valid_i, input, 1, fetch_data_i valid.
REQ-008 SHALL have port fetch_ready_o, output, 1, buffer accepts a line this cycle.
REQ-009 SHALL have port flush_i, input, 1, discard all buffered lines and redirect.
REQ-010 SHALL have port redirect_pc_i, input, 32, new PC, sampled when flush_i=1; bit 0 ignored.
REQ-011 SHALL have port stall, input, 1, decode not consuming this cycle.
REQ-012 SHALL have port inst_o, output, 32, whole instruction to decode; RVC zero-extended in [31:16].
REQ-013 SHALL have port inst_valid_o, output, 1, inst_o holds one complete RV32 or RVC instruction.
REQ-014 SHALL have port inst_pc_o, output, 32, PC of inst_o.

Function
REQ-015 SHALL store up to DEPTH lines in a FIFO; count = number of valid lines, hw_ptr (2 bits) = halfword index of the next instruction within the head line.
REQ-016 SHALL drive fetch_ready_o = (count < DEPTH) && !flush_i, with no combinational path from stall.
REQ-017 SHALL push a line when fetch_valid_i && fetch_ready_o.
REQ-018 SHALL classify the instruction at hw_ptr as RVC when halfword[1:0] != 2'b11, else RV32.
REQ-019 SHALL assert inst_valid_o when count>=1 and, for RV32 at hw_ptr=3, count>=2 (upper halfword from next entry); otherwise 0.
REQ-020 SHALL drive inst_o = 32'h0 whenever inst_valid_o = 0 (bubble).
REQ-021 SHALL consume on inst_valid_o && !stall: hw_ptr += 1 (RVC) or 2 (RV32), modulo 4; inst_pc += 2 or 4.
REQ-022 SHALL pop the head line on consume when hw_ptr + size >= 4; an RV32 spanning lines pops exactly one line, leaving hw_ptr=1.
REQ-023 SHALL allow push and pop in the same cycle; count unchanged.
REQ-024 SHALL, on flush_i=1, set count=0, hw_ptr=redirect_pc_i[2:1], inst_pc=redirect_pc_i & ~1, force inst_valid_o=0, and drop any line offered that cycle.
REQ-025 SHALL give flush_i priority over stall, push and consume in the same cycle.
REQ-026 SHALL present a pushed line to decode no earlier than the following cycle (1-cycle latency, registered storage).
REQ-027 SHALL hold inst_o, inst_pc_o and inst_valid_o stable while stall=1 and no flush.

Reset
REQ-028 SHALL on rst=0 clear count and all entries, set hw_ptr=BOOT_ADDR[2:1], inst_pc=BOOT_ADDR.
REQ-029 SHALL, while rst=0, drive inst_valid_o=0, inst_o=0, fetch_ready_o=0.
REQ-030 SHALL, after reset mid-operation, discard all partially consumed lines with no instruction replayed.

Structure
REQ-031 SHALL place the halfword-index typedef and RVC length predicate in liborv32s, reusing is_inst_rvc from libdecode.
REQ-032 SHALL isolate halfword extraction/alignment in one combinational sub-module inst_align (head+next line, hw_ptr -> inst_o, size).

Verification
REQ-033 SHALL verify: reset BOOT_ADDR=0, push line 64'h00000013_00000013 -> two RV32 0x00000013, PCs 0x0,0x4, line popped after second.
REQ-034 SHALL verify: line of four RVC 16'h0001 -> four instructions 0x00000001 at PCs 0,2,4,6 on consecutive unstalled cycles.
REQ-035 SHALL verify: halfwords {RVC 0x0001, RVC 0x0001, RVC 0x0001, low of RV32 0x0013} then next line [15:0]=0x0000 -> spanning inst 0x00000013 at PC 6 only after second push; hw_ptr=1 afterwards.
REQ-036 SHALL verify: DEPTH=2 full, stall=1 for 5 cycles -> fetch_ready_o=0, inst_o/inst_pc_o constant; release -> resumes without loss.
REQ-037 SHALL verify: flush_i with redirect_pc_i=0x0000_0106 concurrent with push -> line dropped, next line's halfword 3 issued at PC 0x106.
REQ-038 SHALL verify: rst deasserted-then-asserted mid-line -> inst_valid_o=0 immediately, restart at BOOT_ADDR.
